// File: rtl/service_gate_seq_if.sv
// Command and gate-output bundle for service_gate_seq.
interface service_gate_seq_if #(
    parameter int NREG = 8,
    parameter int AW   = 3
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            rd_en;
    logic            wr_en;
    logic            clr_en;
    logic            ci_req;
    logic [AW-1:0]   rd_sel;
    logic [AW-1:0]   wr_sel;
    logic            ginh;
    logic [NREG-1:0] rg_n;
    logic [NREG-1:0] cg;
    logic [NREG-1:0] wg_n;
    logic            ci01_n;
    logic            busy;
    logic            sel_err;

    modport master (
        output cmd_valid, rd_en, wr_en, clr_en, ci_req, rd_sel, wr_sel, ginh,
        input  cmd_ready, rg_n, cg, wg_n, ci01_n, busy, sel_err
    );

    modport slave (
        input  cmd_valid, rd_en, wr_en, clr_en, ci_req, rd_sel, wr_sel, ginh,
        output cmd_ready, rg_n, cg, wg_n, ci01_n, busy, sel_err
    );
endinterface

// File: rtl/service_gate_seq.sv
// Read/clear/write gate sequencer: each accepted command runs RPH, CPH, WPH
// phases of PH_LEN cycles, driving registered one-hot register gates.
module service_gate_seq #(
    parameter int NREG   = 8,
    parameter int AW     = 3,
    parameter int PH_LEN = 1
) (
    input logic              sim_clk,
    input logic              sim_rst,
    service_gate_seq_if.slave bus
);
    localparam int CW = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PH_LEN - 1);

    typedef enum logic [1:0] {IDLE, RPH, CPH, WPH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            last;
    logic            accept;
    logic            rd_en_l, wr_en_l, clr_en_l;
    logic [AW-1:0]   rd_sel_l, wr_sel_l;
    logic            ci_ff;
    logic            sel_err_q;
    logic [NREG-1:0] rg_n_q, cg_q, wg_n_q;

    function automatic logic sel_ok(input logic [AW-1:0] s);
        return 32'(s) < NREG;
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] s);
        return {{(NREG-1){1'b0}}, 1'b1} << s;
    endfunction

    assign last          = (cnt == CNT_LAST);
    assign bus.cmd_ready = (state == IDLE) || (state == WPH && last);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge sim_clk or negedge sim_rst) begin
        if (!sim_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // An accept always wins, which gives the back-to-back WPH -> RPH path.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = RPH;
            cnt_nxt   = '0;
        end else if (state != IDLE) begin
            if (!last) begin
                cnt_nxt = cnt + 1'b1;
            end else begin
                cnt_nxt = '0;
                case (state)
                    RPH:     state_nxt = CPH;
                    CPH:     state_nxt = WPH;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sim_clk or negedge sim_rst) begin
        if (!sim_rst) begin
            rd_en_l   <= 1'b0;
            wr_en_l   <= 1'b0;
            clr_en_l  <= 1'b0;
            rd_sel_l  <= '0;
            wr_sel_l  <= '0;
            ci_ff     <= 1'b0;
            sel_err_q <= 1'b0;
            rg_n_q    <= '1;
            cg_q      <= '0;
            wg_n_q    <= '1;
        end else begin
            sel_err_q <= 1'b0;
            if (accept) begin
                rd_en_l   <= bus.rd_en;
                wr_en_l   <= bus.wr_en;
                clr_en_l  <= bus.clr_en;
                rd_sel_l  <= bus.rd_sel;
                wr_sel_l  <= bus.wr_sel;
                ci_ff     <= bus.ci_req;
                sel_err_q <= !sel_ok(bus.rd_sel) || !sel_ok(bus.wr_sel);
                rg_n_q    <= (bus.rd_en && sel_ok(bus.rd_sel)) ? ~onehot(bus.rd_sel) : '1;
                cg_q      <= '0;
                wg_n_q    <= '1;
            end else if (last) begin
                // GINH is deliberately sampled live in the final CPH cycle.
                case (state)
                    RPH: cg_q <= (clr_en_l && wr_en_l && sel_ok(wr_sel_l)) ? onehot(wr_sel_l) : '0;
                    CPH: begin
                        rg_n_q <= '1;
                        cg_q   <= '0;
                        wg_n_q <= (wr_en_l && !bus.ginh && sel_ok(wr_sel_l)) ? ~onehot(wr_sel_l) : '1;
                    end
                    WPH: begin
                        wg_n_q <= '1;
                        ci_ff  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rg_n    = rg_n_q;
    assign bus.cg      = cg_q;
    assign bus.wg_n    = wg_n_q;
    assign bus.ci01_n  = ~ci_ff;
    assign bus.busy    = (state != IDLE);
    assign bus.sel_err = sel_err_q;
endmodule

// File: doc/service_gate_seq.md
SERVICE_GATE_SEQ -- requirements
Module: service_gate_seq

Interface
REQ-001 Parameter NREG, default 8, number of gated registers (2..64).
REQ-002 Parameter AW, default 3, select width; NREG SHALL be at most 2^AW.
REQ-003 Parameter PH_LEN, default 1, cycles per phase (1..16).
REQ-004 SIM_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 SIM_RST  in  1  reset, asynchronous, active-low.
REQ-006 CMD_VALID  in  1  command offered.
REQ-007 CMD_READY  out  1  command accepted when CMD_VALID and CMD_READY are both high at a rising edge.
REQ-008 RD_EN, WR_EN, CLR_EN, CI_REQ  in  1 each  read, write, clear and carry-in requests of the command.
REQ-009 RD_SEL, WR_SEL  in  AW each  read and write register selects.
REQ-010 GINH  in  1  write-gate inhibit.
REQ-011 RG_n  out  NREG  read gates, active-low, one-hot-low.
REQ-012 CG  out  NREG  clear gates, active-high.
REQ-013 WG_n  out  NREG  write gates, active-low.
REQ-014 CI01_n  out  1  carry-in into bit 1, active-low.
REQ-015 BUSY  out  1  high in any phase other than IDLE.
REQ-016 SEL_ERR  out  1  one-cycle pulse on an out-of-range select.

Function
REQ-017 FSM states: IDLE, RPH, CPH, WPH, visited in that order; a per-phase counter SHALL hold each state for exactly PH_LEN cycles.
REQ-018 CMD_READY SHALL be high in IDLE and in the last cycle of WPH, and low otherwise.
REQ-019 On accept, all command fields SHALL be latched and the next state SHALL be RPH; later input changes SHALL have no effect until the next accept.
REQ-020 Last WPH cycle with no accept: next state IDLE. Accept in that cycle: next state RPH (back-to-back, no idle gap).
REQ-021 All gate outputs SHALL be registered and SHALL change only at phase boundaries.
REQ-022 RG_n[RD_SEL] SHALL be low throughout RPH and CPH if RD_EN was set; all other RG_n bits SHALL stay high.
REQ-023 CG[WR_SEL] SHALL be high throughout CPH if CLR_EN and WR_EN were both set.
REQ-024 WG_n[WR_SEL] SHALL be low throughout WPH if WR_EN was set and GINH was low in the last CPH cycle; otherwise all WG_n bits SHALL stay high for that WPH.
REQ-025 RD_SEL equal to WR_SEL SHALL be legal; both gates SHALL assert in their own phases.
REQ-026 A latched select of NREG or above SHALL suppress that gate for the whole command.
REQ-027 Such a select SHALL pulse SEL_ERR high for the single cycle after accept; the phases SHALL still run to completion.
REQ-028 A carry-in flip-flop SHALL be set on accept when CI_REQ is high, and cleared at the end of the last WPH cycle.
REQ-029 CI01_n SHALL equal the inverse of the carry-in flip-flop.
REQ-030 On a back-to-back accept with CI_REQ high, the flip-flop SHALL stay set without a gap.
REQ-031 Latency: for an accept at edge k, RPH starts at edge k+1, CPH at k+1+PH_LEN and WPH at k+1+2*PH_LEN; each command occupies 3*PH_LEN cycles.

Reset
REQ-032 While SIM_RST is low, the following SHALL hold immediately, without waiting for a clock edge:
- FSM in IDLE, phase counter 0;
- RG_n and WG_n all ones, CG all zeros;
- CI01_n 1, BUSY 0, SEL_ERR 0, CMD_READY 1.
REQ-033 A reset asserted mid-command SHALL abort the command; no gate SHALL reassert after release until a new accept.

Verification
REQ-034 NREG=8, PH_LEN=1. Accept RD_EN=1 RD_SEL=2, WR_EN=1 CLR_EN=1 WR_SEL=5, GINH=0 -> RG_n=8'hFB for 2 cycles, CG=8'h20 in cycle 2, WG_n=8'hDF in cycle 3, then IDLE.
REQ-035 PH_LEN=3. Same command plus CI_REQ=1 -> each phase lasts 3 cycles; CI01_n low for 9 cycles, high on the following cycle.
REQ-036 GINH=1 during CPH -> WG_n stays 8'hFF in WPH; CG still pulses 8'h20.
REQ-037 NREG=6, AW=3, WR_SEL=7 -> SEL_ERR high for 1 cycle, CG and WG_n never assert, BUSY high for 3 cycles.
REQ-038 Two commands offered back-to-back -> second accepted in the last WPH cycle of the first; RPH of the second follows with zero idle cycles and BUSY stays high.
REQ-039 SIM_RST pulsed low during CPH -> CG drops to 0 asynchronously; after release all outputs stay at reset values until the next accept.
